burst_seq_checker: RTL and testbench

- Downstream consumer of the 16-bit word stream produced by the burst-sequence stage. That stage emits bursts of BURST_LEN words: base, base+1, base+2, ... spaced by idle gaps.
- This block samples each qualified word and confirms that every burst is a correctly incrementing run. It reports each completed burst's base value and counts good and bad bursts.
- Sits between the burst producer and the self-check/scoreboard logic of the lab bench. It is synthesizable and runs on a single clock.

---
 rtl/burst_seq_checker.sv | 140 ++++++++++++++
 tb/tb_burst_seq_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_seq_checker.sv
// Checks that each burst of BURST_LEN words on din is a base, base+1, ... run.
// Reports the base of each good burst and keeps saturating good/bad burst counts.
module burst_seq_checker #(
   parameter int WIDTH     = 16,
   parameter int BURST_LEN = 3,
   parameter int GAP_MAX   = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din,
   input  logic             cnt_clr,
   output logic             busy,
   output logic             burst_done,
   output logic [WIDTH-1:0] burst_base,
   output logic             err,
   output logic [CNT_W-1:0] ok_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int IDX_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
   localparam int GAP_W = (GAP_MAX > 2) ? $clog2(GAP_MAX) : 1;

   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_base;
   logic [IDX_W-1:0] r_idx;
   logic [GAP_W-1:0] r_gap;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [WIDTH-1:0] r_burst_base;
   logic [CNT_W-1:0] r_ok_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   logic [WIDTH-1:0] w_expect;
   logic             w_match;
   logic             w_last;
   logic             w_timeout;
   logic             w_ok_inc;
   logic             w_err_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_expect = r_base + WIDTH'(r_idx);
   assign w_match  = (din == w_expect);
   assign w_last   = (r_idx == IDX_W'(BURST_LEN - 1));
   // Fires on the idle cycle that brings the gap count to GAP_MAX-1.
   assign w_timeout = (r_gap == GAP_W'(GAP_MAX - 2));

   always_comb begin
      w_ok_inc  = 1'b0;
      w_err_inc = 1'b0;
      if (r_state == S_COLLECT) begin
         w_ok_inc  = din_valid && w_match && w_last;
         w_err_inc = (din_valid && !w_match) || (!din_valid && w_timeout);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_base       <= '0;
         r_idx        <= '0;
         r_gap        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_burst_base <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (din_valid) begin
                  r_base  <= din;
                  r_idx   <= IDX_W'(1);
                  r_gap   <= '0;
                  r_state <= S_COLLECT;
                  r_busy  <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (din_valid && w_match) begin
                  if (w_last) begin
                     r_done       <= 1'b1;
                     r_burst_base <= r_base;
                     r_state      <= S_IDLE;
                     r_busy       <= 1'b0;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                     r_gap <= '0;
                  end
               end else if (din_valid) begin
                  // Mismatching word becomes the base of a fresh burst.
                  r_err  <= 1'b1;
                  r_base <= din;
                  r_idx  <= IDX_W'(1);
                  r_gap  <= '0;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap <= r_gap + GAP_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ok_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (cnt_clr) begin
         r_ok_cnt  <= '0;
         r_err_cnt <= '0;
      end else begin
         if (w_ok_inc)  r_ok_cnt  <= sat_inc(r_ok_cnt);
         if (w_err_inc) r_err_cnt <= sat_inc(r_err_cnt);
      end
   end

   assign busy       = r_busy;
   assign burst_done = r_done;
   assign burst_base = r_burst_base;
   assign err        = r_err;
   assign ok_count   = r_ok_cnt;
   assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_burst_seq_checker.sv
// Bench for burst_seq_checker: word-count/idle-time reference model checked every
// cycle, plus literal expectations at the end of each directed scenario.
module tb_burst_seq_checker;

   localparam int WIDTH     = 16;
   localparam int BURST_LEN = 3;
   localparam int GAP_MAX   = 16;
   localparam int CNT_W     = 2;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             din_valid = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             cnt_clr = 1'b0;
   logic             busy;
   logic             burst_done;
   logic [WIDTH-1:0] burst_base;
   logic             err;
   logic [CNT_W-1:0] ok_count;
   logic [CNT_W-1:0] err_count;

   int checks = 0;
   int errors = 0;

   burst_seq_checker #(
      .WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .GAP_MAX(GAP_MAX), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
      .busy(busy), .burst_done(burst_done), .burst_base(burst_base), .err(err),
      .ok_count(ok_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Reference model: a burst is "words seen so far" plus "idle clocks since the last word".
   bit          m_in_burst;
   int          m_words;
   int          m_idle;
   int          m_base;
   bit          m_done;
   bit          m_err;
   int          m_bbase;
   int          m_ok;
   int          m_errc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_in_burst = 0; m_words = 0; m_idle = 0; m_base = 0;
         m_done = 0; m_err = 0; m_bbase = 0; m_ok = 0; m_errc = 0;
      end else begin
         bit good, bad;
         good = 0; bad = 0;
         m_done = 0; m_err = 0;
         if (!m_in_burst) begin
            if (din_valid) begin
               m_in_burst = 1; m_base = int'(din); m_words = 1; m_idle = 0;
            end
         end else if (din_valid) begin
            if (int'(din) == ((m_base + m_words) % (1 << WIDTH))) begin
               m_words++; m_idle = 0;
               if (m_words == BURST_LEN) begin
                  good = 1; m_done = 1; m_bbase = m_base; m_in_burst = 0;
               end
            end else begin
               bad = 1; m_err = 1;
               m_base = int'(din); m_words = 1; m_idle = 0;
            end
         end else begin
            m_idle++;
            if (m_idle == GAP_MAX - 1) begin
               bad = 1; m_err = 1; m_in_burst = 0;
            end
         end
         if (cnt_clr) begin
            m_ok = 0; m_errc = 0;
         end else begin
            if (good && m_ok < CNT_MAX) m_ok++;
            if (bad && m_errc < CNT_MAX) m_errc++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("busy",       int'(busy),       int'(m_in_burst));
      chk("burst_done", int'(burst_done), int'(m_done));
      chk("err",        int'(err),        int'(m_err));
      chk("burst_base", int'(burst_base), m_bbase);
      chk("ok_count",   int'(ok_count),   m_ok);
      chk("err_count",  int'(err_count),  m_errc);
      chk("done_err_excl", int'(burst_done && err), 0);
   end

   task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit c);
      din_valid = v; din = d; cnt_clr = c;
      @(posedge clk); #1;
      din_valid = 0; cnt_clr = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0);
   endtask

   task automatic word(input logic [WIDTH-1:0] d);
      cyc(1, d, 0);
   endtask

   int dones;
   always @(negedge clk) if (burst_done) dones++;

   initial begin
      dones = 0;
      #12;
      chk("reset_busy", int'(busy), 0);
      chk("reset_ok",   int'(ok_count), 0);
      chk("reset_base", int'(burst_base), 0);
      rst_n = 1;
      @(posedge clk); #1;

      // Clean burst, one word every 10 clocks.
      word(16'h0000); idle(9); word(16'h0001); idle(9); word(16'h0002);
      chk("clean_done", int'(burst_done), 1);
      chk("clean_base", int'(burst_base), 16'h0000);
      chk("clean_ok",   int'(ok_count), 1);
      chk("clean_err",  int'(err_count), 0);
      chk("clean_busy", int'(busy), 0);
      idle(2); cyc(0, '0, 1);

      // Back-to-back bursts with no gap.
      word(16'h0010); word(16'h0011); word(16'h0012);
      chk("b2b_base0", int'(burst_base), 16'h0010);
      word(16'h0020); word(16'h0021); word(16'h0022);
      chk("b2b_base1", int'(burst_base), 16'h0020);
      chk("b2b_ok",    int'(ok_count), 2);
      idle(2); cyc(0, '0, 1);

      // Wrap through zero.
      word(16'hFFFF); word(16'h0000); word(16'h0001);
      chk("wrap_done", int'(burst_done), 1);
      chk("wrap_base", int'(burst_base), 16'hFFFF);
      chk("wrap_err",  int'(err_count), 0);
      idle(2); cyc(0, '0, 1);

      // Mismatch then resync on the offending word.
      word(16'h0005); word(16'h0006); word(16'h0009);
      chk("mis_err", int'(err), 1);
      chk("mis_busy", int'(busy), 1);
      word(16'h000A); word(16'h000B);
      chk("mis_base", int'(burst_base), 16'h0009);
      chk("mis_ok",   int'(ok_count), 1);
      chk("mis_errc", int'(err_count), 1);
      idle(2); cyc(0, '0, 1);

      // Timeout: second word 16 clocks after the first.
      word(16'h0030); idle(15);
      chk("to_err",  int'(err), 1);
      chk("to_busy", int'(busy), 0);
      word(16'h0031);
      chk("to_restart", int'(busy), 1);
      word(16'h0032); word(16'h0033);
      chk("to_newbase", int'(burst_base), 16'h0031);
      idle(2); cyc(0, '0, 1);

      // Boundary: word arrives on the cycle the timeout would fire.
      word(16'h0030); idle(14); word(16'h0031);
      chk("bnd_noerr", int'(err), 0);
      word(16'h0032);
      chk("bnd_base", int'(burst_base), 16'h0030);
      chk("bnd_errc", int'(err_count), 0);
      idle(2);

      // Reset mid-burst.
      word(16'h0040); word(16'h0041);
      #2 rst_n = 0; #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_base", int'(burst_base), 0);
      chk("rst_ok",   int'(ok_count), 0);
      chk("rst_err",  int'(err), 0);
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;

      // Saturation then clear coincident with burst_done.
      dones = 0;
      for (int b = 0; b < 5; b++) begin
         word(16'(16'h0100 * b)); word(16'(16'h0100 * b + 1)); word(16'(16'h0100 * b + 2));
         idle(1);
      end
      chk("sat_dones", dones, 5);
      chk("sat_ok", int'(ok_count), 3);
      word(16'h0700); word(16'h0701); cyc(1, 16'h0702, 1);
      chk("clr_done", int'(burst_done), 1);
      chk("clr_ok",   int'(ok_count), 0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
